// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Register file write-port controller: post-reset zero sweep of
//               x1..x(2^ADDR_W-1), then core-priority arbitration against a
//               debug requester with a starvation-bounded forced stall.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    input  logic              clr_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_last = '1;
    localparam logic [3:0]        c_max_wait  = 4'(MAX_WAIT);

    state_t            r_state_q,    w_state_d;
    logic [ADDR_W-1:0] r_clr_addr_q, w_clr_addr_d;
    logic [3:0]        r_wait_cnt_q, w_wait_cnt_d;

    logic w_forced;
    logic w_core_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q    <= ST_INIT;
            r_clr_addr_q <= c_addr_one;
            r_wait_cnt_q <= 4'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_clr_addr_q <= w_clr_addr_d;
            r_wait_cnt_q <= w_wait_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_clr_addr_d = r_clr_addr_q;
        w_wait_cnt_d = 4'd0;
        w_forced     = 1'b0;
        w_core_wr    = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        core_stall   = 1'b1;
        dbg_ready    = 1'b0;
        init_done    = 1'b0;

        // Outputs are held at their idle values for the whole time rst is low.
        if (rst) begin
            case (r_state_q)
                ST_INIT: begin
                    rf_we    = 1'b1;
                    rf_waddr = r_clr_addr_q;
                    if (r_clr_addr_q == c_addr_last) begin
                        w_state_d    = ST_RUN;
                        w_clr_addr_d = c_addr_one;
                    end else begin
                        w_clr_addr_d = r_clr_addr_q + c_addr_one;
                    end
                end
                ST_RUN: begin
                    init_done  = 1'b1;
                    w_forced   = (r_wait_cnt_q == c_max_wait);
                    core_stall = w_forced;
                    w_core_wr  = !w_forced && core_we && (core_waddr != '0);
                    if (w_core_wr) begin
                        rf_we    = 1'b1;
                        rf_waddr = core_waddr;
                        rf_wdata = core_wdata;
                    end else begin
                        dbg_ready = 1'b1;
                        rf_we     = dbg_valid && (dbg_waddr != '0);
                        rf_waddr  = dbg_waddr;
                        rf_wdata  = dbg_wdata;
                    end
                    // Count only cycles where a pending request lost to the core.
                    if (dbg_valid && !dbg_ready) begin
                        w_wait_cnt_d = r_wait_cnt_q + 4'd1;
                    end
                    if (clr_req) begin
                        w_state_d    = ST_INIT;
                        w_clr_addr_d = c_addr_one;
                        w_wait_cnt_d = 4'd0;
                    end
                end
                default: begin
                    w_state_d    = ST_INIT;
                    w_clr_addr_d = c_addr_one;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        dbg_valid;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic        clr_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;

    int n_vec;
    int n_err;

    regfile_write_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MAX_WAIT (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .dbg_valid  (dbg_valid),
        .dbg_waddr  (dbg_waddr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ready  (dbg_ready),
        .clr_req    (clr_req),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .init_done  (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed view {rf_we, rf_waddr, rf_wdata, core_stall, dbg_ready, init_done}.
    function automatic logic [40:0] outs();
        return {rf_we, rf_waddr, rf_wdata, core_stall, dbg_ready, init_done};
    endfunction

    // Inputs change 1 unit after a rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_we    = 1'b0;
        core_waddr = 5'd0;
        core_wdata = 32'd0;
        dbg_valid  = 1'b0;
        dbg_waddr  = 5'd0;
        dbg_wdata  = 32'd0;
        clr_req    = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] exp;
        rst = 1'b1;
        idle_inputs();
        #1 rst = 1'b0;
        next_cycle();
        #2;
        exp = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", outs(), exp);
        end
        next_cycle();
        rst = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            #2;
            exp = {1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0};
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL sweep_x%0d: got %h want %h", i, outs(), exp);
            end
            next_cycle();
        end
        #2;
        exp = {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL run_entry: got %h want %h", outs(), exp);
        end
        next_cycle();
    endtask

    task automatic test_core_write();
        logic [40:0] exp;
        core_we    = 1'b1;
        core_waddr = 5'd5;
        core_wdata = 32'hDEADBEEF;
        #2;
        exp = {1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL core_write: got %h want %h", outs(), exp);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_dbg_write();
        logic [40:0] exp;
        dbg_valid = 1'b1;
        dbg_waddr = 5'd7;
        dbg_wdata = 32'h12;
        #2;
        exp = {1'b1, 5'd7, 32'h12, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL dbg_write: got %h want %h", outs(), exp);
        end
        next_cycle();
        idle_inputs();
        #2;
        exp = {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL dbg_idle_after: got %h want %h", outs(), exp);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [40:0] exp;
        core_we    = 1'b1;
        core_waddr = 5'd3;
        core_wdata = 32'h0000AAAA;
        dbg_valid  = 1'b1;
        dbg_waddr  = 5'd9;
        dbg_wdata  = 32'h99;
        for (int k = 0; k < 4; k++) begin
            #2;
            exp = {1'b1, 5'd3, 32'h0000AAAA, 1'b0, 1'b0, 1'b1};
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL starve_blocked_%0d: got %h want %h", k, outs(), exp);
            end
            next_cycle();
        end
        #2;
        exp = {1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL starve_forced: got %h want %h", outs(), exp);
        end
        next_cycle();
        dbg_valid = 1'b0;
        #2;
        exp = {1'b1, 5'd3, 32'h0000AAAA, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL starve_release: got %h want %h", outs(), exp);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_addr_zero();
        logic [40:0] exp;
        dbg_valid = 1'b1;
        dbg_waddr = 5'd0;
        dbg_wdata = 32'h55;
        #2;
        exp = {1'b0, 5'd0, 32'h55, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL dbg_x0_dropped: got %h want %h", outs(), exp);
        end
        next_cycle();
        core_we    = 1'b1;
        core_waddr = 5'd0;
        core_wdata = 32'h77;
        dbg_waddr  = 5'd4;
        dbg_wdata  = 32'h44;
        #2;
        exp = {1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL core_x0_dbg_wins: got %h want %h", outs(), exp);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_clear_and_reset();
        logic [40:0] exp;
        core_we    = 1'b1;
        core_waddr = 5'd6;
        core_wdata = 32'h66;
        clr_req    = 1'b1;
        #2;
        exp = {1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL clr_req_cycle: got %h want %h", outs(), exp);
        end
        next_cycle();
        idle_inputs();
        for (int i = 1; i <= 10; i++) begin
            #2;
            exp = {1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0};
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL clr_sweep_x%0d: got %h want %h", i, outs(), exp);
            end
            if (i < 10) next_cycle();
        end
        rst       = 1'b0;
        dbg_valid = 1'b1;
        dbg_waddr = 5'd12;
        dbg_wdata = 32'hC;
        for (int k = 0; k < 2; k++) begin
            #2;
            exp = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL mid_reset_%0d: got %h want %h", k, outs(), exp);
            end
            next_cycle();
        end
        rst = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            #2;
            exp = {1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0};
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL resweep_x%0d: got %h want %h", i, outs(), exp);
            end
            next_cycle();
        end
        #2;
        exp = {1'b1, 5'd12, 32'hC, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL pending_dbg_ack: got %h want %h", outs(), exp);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_core_write();
        test_dbg_write();
        test_starvation();
        test_addr_zero();
        test_clear_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Controller in front of the 32x32 register file write port. After reset it sequences a zero-clear sweep of x1..x31, then shares the single write port between core writeback (priority) and a debug/loader requester using a valid/ready handshake. A starvation counter forces a one-cycle core stall so that debug writes always complete. Sits between the core writeback stage, the debug unit and the register file's we/WriteAddr/WriteData inputs.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (registers 0..2^ADDR_W-1; x0 never written)
MAX_WAIT, 4, cycles a pending debug write may be blocked by core writes before the core is stalled (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
core_we  input  1  core writeback enable
core_waddr  input  ADDR_W  core writeback address
core_wdata  input  DATA_W  core writeback data
core_stall  output  1  core must hold PC/writeback; core_we ignored while 1
dbg_valid  input  1  debug write request
dbg_waddr  input  ADDR_W  debug write address
dbg_wdata  input  DATA_W  debug write data
dbg_ready  output  1  debug write accepted this cycle when dbg_valid=1
clr_req  input  1  single-cycle pulse: restart the clear sweep (sampled in RUN only)
rf_we  output  1  to register file we
rf_waddr  output  ADDR_W  to register file WriteAddr
rf_wdata  output  DATA_W  to register file WriteData
init_done  output  1  1 in RUN state

Behaviour:
- State register: INIT, RUN. Registered: state, clr_addr[ADDR_W-1:0], wait_cnt[3:0]. rf_*, core_stall, dbg_ready are combinational from the registers and inputs.
- rst=0 (async): state=INIT, clr_addr=1, wait_cnt=0. While rst=0: rf_we=0, rf_waddr=0, rf_wdata=0, core_stall=1, dbg_ready=0, init_done=0.
- INIT (rst=1): rf_we=1, rf_waddr=clr_addr, rf_wdata=0, core_stall=1, dbg_ready=0, init_done=0. clr_addr increments each cycle; on the cycle clr_addr=2^ADDR_W-1, next state=RUN, clr_addr=1. Sweep length is 31 cycles for ADDR_W=5. dbg_valid and clr_req are ignored.
- RUN, normal (wait_cnt<MAX_WAIT): core_stall=0. A core write is a core_we=1 with core_waddr!=0.
  - Core write present: rf_we=1, rf_waddr/rf_wdata=core_*, dbg_ready=0.
  - Otherwise: dbg_ready=1. rf_we=dbg_valid && dbg_waddr!=0, rf_waddr/rf_wdata=dbg_*.
- RUN, forced (wait_cnt==MAX_WAIT): core_stall=1, dbg_ready=1, debug drives the port as above, and core_we is ignored.
- wait_cnt: cleared when dbg_valid=0 or when a handshake (dbg_valid&&dbg_ready) completes. Incremented when dbg_valid=1 && dbg_ready=0. Never exceeds MAX_WAIT.
- Debug write to address 0: handshake completes (dbg_ready=1) but rf_we=0, so the write is dropped.
- Core write to address 0 counts as no write; debug may take the port in the same cycle.
- clr_req=1 in RUN: next state=INIT, clr_addr=1, wait_cnt=0. The port in the current cycle is still arbitrated normally.
- Debug handshake rule: the requester holds dbg_waddr/dbg_wdata stable while dbg_valid=1 && dbg_ready=0.
- Reset mid-sweep or mid-wait: the sweep restarts from x1 after release. A pending debug request is not acknowledged until the next RUN cycle in which the port is free.
- Throughput: at most one register write per cycle, with zero-latency pass-through to the register file.

Test Plan:
- Release rst at cycle 0, no requests -> rf_we=1 with rf_waddr=1..31 and rf_wdata=0 on 31 consecutive cycles, core_stall=1 throughout, then init_done=1 and core_stall=0.
- In RUN, core_we=1, core_waddr=5, core_wdata=0xDEADBEEF, dbg_valid=0 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, dbg_ready=0.
- In RUN, core_we=0, dbg_valid=1, dbg_waddr=7, dbg_wdata=0x12 -> dbg_ready=1, rf_we=1, rf_waddr=7, rf_wdata=0x12; the next cycle with dbg_valid=0 gives rf_we=0.
- MAX_WAIT=4, core_we=1 to x3 every cycle with dbg_valid=1 to x9 held -> dbg_ready=0 for 4 cycles, then on the 5th cycle core_stall=1, dbg_ready=1, rf_waddr=9. The following cycle has core_stall=0 and the core owns the port again.
- Debug write dbg_waddr=0, core idle -> dbg_ready=1, rf_we=0. Core write core_waddr=0 with dbg_valid=1 to x4 -> debug granted, rf_waddr=4.
- clr_req pulse in RUN, then rst=0 asserted for 2 cycles at sweep address 10 and released -> sweep restarts at rf_waddr=1, all outputs take reset values while rst=0, and init_done=1 only after a full 31-cycle sweep.
